ps2_key_sequencer: RTL

//  Drains the ps2_keyboard receive FIFO, decodes PS/2 set-2 prefixes (E0 extended, F0 break) and emits one

---
 rtl/ps2_key_sequencer_pkg.sv | 31 +++
 rtl/ps2_key_sequencer_if.sv | 26 ++
 rtl/ps2_key_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_sequencer_pkg.sv
// Scan-code constants, FSM state type and key-event record shared by the PS/2 key sequencer.
package ps2_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_ECHO   = 8'hEE;
   localparam logic [7:0] SC_RESEND = 8'hFE;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      GAP,
      OUT_HOLD
   } state_e;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_evt_t;

   // Keyboard status/control bytes that never form part of a key event.
   function automatic logic is_ctrl_byte(input logic [7:0] b);
      return (b == SC_PAUSE) || (b == SC_BAT) || (b == SC_ACK) ||
             (b == SC_ECHO) || (b == SC_RESEND);
   endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Key-event valid/ready bus between the sequencer (master) and its consumer (slave).
interface ps2_key_sequencer_if;

   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;

   modport master (
      output key_valid,
      output key_code,
      output key_ext,
      output key_break,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_code,
      input  key_ext,
      input  key_break,
      output key_ready
   );

endinterface

// File: rtl/ps2_key_sequencer.sv
// Drains the ps2_keyboard FIFO, folds E0/F0 prefixes into one key event per sequence.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of the last make.
module ps2_key_sequencer
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 5_000_000,
   parameter int unsigned TMO_W       = 23
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       kb_ready,
   input  logic [7:0]                 kb_data,
   input  logic                       kb_overflow,
   output logic                       kb_nextdata_n,
   ps2_key_sequencer_if.master        key_if,
   output logic                       err_timeout,
   output logic                       err_overflow,
   input  logic                       err_clr
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_e           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             key_valid_q, key_valid_d;
   key_evt_t         evt_q, evt_d;
   logic             err_timeout_q, err_timeout_d;
   logic             err_ovf_q, err_ovf_d;
   logic             pop;
   logic             emit;
   logic             stall;

`ifdef PS2_REPEAT_FILTER_EN
   logic             last_vld_q, last_vld_d;
   logic [8:0]       last_key_q, last_key_d;
`endif

   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      ext_d         = ext_q;
      brk_d         = brk_q;
      tmo_cnt_d     = tmo_cnt_q;
      key_valid_d   = key_valid_q;
      evt_d         = evt_q;
      err_timeout_d = 1'b0;
      err_ovf_d     = err_ovf_q;
      pop           = 1'b0;
      emit          = 1'b0;
      stall         = key_valid_q && !key_if.key_ready;
`ifdef PS2_REPEAT_FILTER_EN
      last_vld_d    = last_vld_q;
      last_key_d    = last_key_q;
`endif

      if (key_valid_q && key_if.key_ready) begin
         key_valid_d = 1'b0;
      end

      // Timeout clears the flags first; a byte classified this cycle still overrides them.
      if ((ext_q || brk_q) && !kb_ready) begin
         if (tmo_cnt_q == TMO_LAST) begin
            ext_d         = 1'b0;
            brk_d         = 1'b0;
            err_timeout_d = 1'b1;
            tmo_cnt_d     = '0;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end else begin
         tmo_cnt_d = '0;
      end

      unique case (state_q)
         IDLE, OUT_HOLD: begin
            if (stall) begin
               state_d = OUT_HOLD;
            end else if (kb_ready && !reset) begin
               pop     = 1'b1;
               byte_d  = kb_data;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            state_d = GAP;
            if (byte_q == SC_EXT) begin
               ext_d = 1'b1;
            end else if (byte_q == SC_BRK) begin
               brk_d = 1'b1;
            end else begin
               ext_d = 1'b0;
               brk_d = 1'b0;
               emit  = !is_ctrl_byte(byte_q);
`ifdef PS2_REPEAT_FILTER_EN
               if (emit) begin
                  if (brk_q) begin
                     if (last_vld_q && (last_key_q == {ext_q, byte_q})) begin
                        last_vld_d = 1'b0;
                     end
                  end else if (last_vld_q && (last_key_q == {ext_q, byte_q})) begin
                     emit = 1'b0;
                  end else begin
                     last_vld_d = 1'b1;
                     last_key_d = {ext_q, byte_q};
                  end
               end
`endif
            end
         end
         GAP: begin
            state_d = stall ? OUT_HOLD : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new event loading in the same cycle as an accept keeps key_valid high.
      if (emit) begin
         key_valid_d = 1'b1;
         evt_d       = {ext_q, brk_q, byte_q};
      end

      if (kb_overflow) begin
         err_ovf_d = 1'b1;
      end else if (err_clr) begin
         err_ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         byte_q        <= '0;
         ext_q         <= 1'b0;
         brk_q         <= 1'b0;
         tmo_cnt_q     <= '0;
         key_valid_q   <= 1'b0;
         evt_q         <= '0;
         err_timeout_q <= 1'b0;
         err_ovf_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         ext_q         <= ext_d;
         brk_q         <= brk_d;
         tmo_cnt_q     <= tmo_cnt_d;
         key_valid_q   <= key_valid_d;
         evt_q         <= evt_d;
         err_timeout_q <= err_timeout_d;
         err_ovf_q     <= err_ovf_d;
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last_vld_q <= 1'b0;
         last_key_q <= '0;
      end else begin
         last_vld_q <= last_vld_d;
         last_key_q <= last_key_d;
      end
   end
`endif

   assign kb_nextdata_n    = ~pop;
   assign key_if.key_valid = key_valid_q;
   assign key_if.key_code  = evt_q.code;
   assign key_if.key_ext   = evt_q.ext;
   assign key_if.key_break = evt_q.brk;
   assign err_timeout      = err_timeout_q;
   assign err_overflow     = err_ovf_q;

endmodule
